// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM encodings,
// frame-config field positions and default widths.
package uart_pkg;

   localparam int unsigned MAX_DATA_WIDTH_DEF   = 8;
   localparam int unsigned FIFO_DEPTH_DEF       = 16;
   localparam int unsigned FIFO_ADDR_WIDTH_DEF  = 4;
   localparam int unsigned TOTAL_CONF_WIDTH_DEF = 5;

   // Frame config layout: {data[1:0], stop[1:0], parity_en}
   localparam int unsigned CONF_PARITY_BIT = 0;
   localparam int unsigned CONF_STOP_LSB   = 1;
   localparam int unsigned CONF_STOP_MSB   = 2;
   localparam int unsigned CONF_DATA_LSB   = 3;
   localparam int unsigned CONF_DATA_MSB   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOAD   = 2'b01,
      ST_ACTIVE = 2'b10,
      ST_DRAIN  = 2'b11
   } feeder_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and first-word-fall-through
// read data, so a pop and the capture of its head happen in the same cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH      = MAX_DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = FIFO_DEPTH_DEF,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      rd_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   level_o
);

   localparam int unsigned LVL_W = ADDR_WIDTH + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  push_ok;
   logic                  pop_ok;

   // A pop frees the slot in the same cycle, so a push into a full FIFO is
   // accepted whenever a pop accompanies it.
   always_comb begin
      pop_ok   = pop_i && !empty_q;
      push_ok  = push_i && (!full_q || pop_ok);
      wr_ptr_d = push_ok ? (wr_ptr_q + ADDR_WIDTH'(1)) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? (rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == LVL_W'(0));
   end

   // Pointer and status registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array; contents are don't-care after reset since the pointers clear.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign level_o   = level_q;

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// Feeds queued bytes to the UART transmitter one frame at a time.
// Optional sticky overflow flag: define UART_TX_FEEDER_OVERFLOW_EN.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned MAX_DATA_WIDTH   = MAX_DATA_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH       = FIFO_DEPTH_DEF,
   parameter int unsigned FIFO_ADDR_WIDTH  = $clog2(FIFO_DEPTH),
   parameter int unsigned TOTAL_CONF_WIDTH = TOTAL_CONF_WIDTH_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        feed_en_i,
   input  logic [TOTAL_CONF_WIDTH-1:0] conf_i,
   input  logic                        wr_en_i,
   input  logic [MAX_DATA_WIDTH-1:0]   wr_data_i,
   input  logic                        tx_busy_i,
   input  logic                        tx_done_i,
   output logic                        tx_en_o,
   output logic                        tx_start_o,
   output logic [MAX_DATA_WIDTH-1:0]   tx_data_o,
   output logic [TOTAL_CONF_WIDTH-1:0] tx_conf_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [FIFO_ADDR_WIDTH:0]    level_o
`ifdef UART_TX_FEEDER_OVERFLOW_EN
   ,
   input  logic                        overflow_clr_i,
   output logic                        overflow_o
`endif
);

   feeder_state_e               state_q, state_d;
   logic [MAX_DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic [TOTAL_CONF_WIDTH-1:0] tx_conf_q, tx_conf_d;
   logic                        tx_start_q, tx_start_d;
   logic                        tx_en_q, tx_en_d;
   logic                        busy_q, busy_d;
   logic                        fifo_pop;
   logic [MAX_DATA_WIDTH-1:0]   fifo_rd_data;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [FIFO_ADDR_WIDTH:0]    fifo_level;

   uart_sync_fifo #(
      .WIDTH      (MAX_DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (wr_en_i),
      .wr_data_i (wr_data_i),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   // Frame sequencing; data/conf are captured only on the IDLE->LOAD step so
   // mid-frame conf_i changes never reach the transmitter.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      tx_conf_d = tx_conf_q;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (feed_en_i && !fifo_empty) begin
               fifo_pop  = 1'b1;
               tx_data_d = fifo_rd_data;
               tx_conf_d = conf_i;
               state_d   = ST_LOAD;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (tx_busy_i) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_ACTIVE: begin
            if (busy_q && !tx_busy_i) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_DRAIN: begin
            // Waiting out the done level keeps one completion from being seen twice.
            if (!tx_done_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      tx_start_d = (state_q == ST_LOAD) && !tx_busy_i;
      tx_en_d    = feed_en_i;
      busy_d     = tx_busy_i;
   end

   // FSM state and registered transmitter-facing outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         tx_data_q  <= '0;
         tx_conf_q  <= '0;
         tx_start_q <= 1'b0;
         tx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_conf_q  <= tx_conf_d;
         tx_start_q <= tx_start_d;
         tx_en_q    <= tx_en_d;
         busy_q     <= busy_d;
      end
   end

`ifdef UART_TX_FEEDER_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // Sticky drop flag; a set in the same cycle as a clear takes priority.
   always_comb begin
      if (wr_en_i && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr_i) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow_o = overflow_q;
`endif

   assign tx_en_o    = tx_en_q;
   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign tx_conf_o  = tx_conf_q;
   assign full_o     = fifo_full;
   assign empty_o    = fifo_empty;
   assign level_o    = fifo_level;

endmodule : uart_tx_feeder

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmitter.
- Buffers bytes written by the host/register interface in a synchronous FIFO.
- Pops one entry per frame and drives the transmitter's start/data/config inputs, handshaking on its busy/done outputs so frames go back-to-back without data loss.

Parameters:
- MAX_DATA_WIDTH, 8, width of one FIFO entry and of tx_data_o
- FIFO_DEPTH, 16, number of entries; power of two, minimum 2
- FIFO_ADDR_WIDTH, 4, set to $clog2(FIFO_DEPTH)
- TOTAL_CONF_WIDTH, 5, frame config width {data[1:0], stop[1:0], parity_en}

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- feed_en_i  in  1  block enable; also forwarded as transmitter enable
- conf_i  in  TOTAL_CONF_WIDTH  frame configuration from the register block
- wr_en_i  in  1  push wr_data_i this cycle
- wr_data_i  in  MAX_DATA_WIDTH  byte to queue
- tx_busy_i  in  1  transmitter busy
- tx_done_i  in  1  transmitter done; level held for one baud-tick period
- tx_en_o  out  1  transmitter enable
- tx_start_o  out  1  frame start request
- tx_data_o  out  MAX_DATA_WIDTH  byte for the current frame
- tx_conf_o  out  TOTAL_CONF_WIDTH  configuration for the current frame
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- level_o  out  FIFO_ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset values:
  - tx_start_o=0, tx_data_o=0, tx_conf_o=0, tx_en_o=0.
  - empty_o=1, full_o=0, level_o=0.
  - FSM in IDLE; both pointers at 0.
- tx_en_o is a registered copy of feed_en_i (1-cycle delay).
- FIFO:
  - Push when wr_en_i && !full_o. A push while full is dropped; contents are unchanged.
  - Pop is internal only, generated by the FSM.
  - Simultaneous push and pop: both succeed, level unchanged. This applies even when full, because the pop frees the slot in the same cycle.
  - Pointers are FIFO_ADDR_WIDTH bits and wrap modulo FIFO_DEPTH.
  - level_o, full_o and empty_o are registered and update the cycle after the push/pop.
- FSM states:
  - IDLE: if feed_en_i && !empty_o, pop the head, register it into tx_data_o, register conf_i into tx_conf_o, go to LOAD.
  - LOAD: assert tx_start_o=1. Stay until tx_busy_i==1, then go to ACTIVE.
  - ACTIVE: tx_start_o=0; tx_data_o and tx_conf_o held stable. Go to DRAIN on the tx_busy_i 1->0 edge, detected with a one-cycle registered copy of busy.
  - DRAIN: wait until tx_done_i==0, then go to IDLE. This prevents one done level being counted twice.
- tx_data_o and tx_conf_o change only on the IDLE->LOAD transition. A conf_i change mid-frame does not affect the current frame.
- Latency: with a non-empty FIFO and enable high, tx_start_o rises 2 clocks after IDLE is entered (pop cycle + register).
- feed_en_i deasserted:
  - In IDLE: no pop.
  - In LOAD, ACTIVE or DRAIN: the current frame completes normally, and the FSM returns to IDLE and holds there.
- Reset mid-frame: all state clears immediately and FIFO contents are discarded; the transmitter is reset by the same rst_i.
- Unused or illegal FSM encodings go to IDLE.

Optional Feature:
- Macro: UART_TX_FEEDER_OVERFLOW_EN.
- When defined:
  - Extra outputs: overflow_o (1 bit, sticky) and overflow_clr_i (input).
  - overflow_o sets on any wr_en_i while full_o with no simultaneous pop.
  - overflow_o clears on overflow_clr_i. If set and clear occur in the same cycle, set wins.
  - overflow_o resets to 0.
- When undefined: the ports are absent and dropped writes are silent.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings: IDLE=2'b00, LOAD=2'b01, ACTIVE=2'b10, DRAIN=2'b11.
  - Conf field bit positions: parity=0, stop=2:1, data=4:3.
  - Default widths.
- One sub-module, uart_sync_fifo:
  - Parameterised width/depth storage, pointers, level, full and empty.
  - Exposes push/pop/data/status.
- The feeder instantiates uart_sync_fifo and contains the FSM and output registers.

Test Plan:
- Push 0x55 with enable high and a transmitter model (busy 20 clocks after start, done then low) -> tx_start_o high within 2 clocks, tx_data_o=0x55, start drops when busy rises, FSM returns to IDLE with level_o=0.
- Push 0xA1, 0xB2, 0xC3 back-to-back -> three frames issued in order; tx_data_o changes only between frames; exactly 3 starts counted.
- Fill 16 entries, then push 0xFF -> full_o=1, 17th write dropped, level_o=16. With the macro defined, overflow_o=1 until overflow_clr_i.
- While full and in IDLE, push and pop in the same cycle -> level_o stays 16, new byte appears last in the output order.
- Assert rst_i during ACTIVE with 5 entries queued -> next cycle: tx_start_o=0, level_o=0, empty_o=1; no further starts.
- Drop feed_en_i during ACTIVE with 2 entries queued -> current frame completes, no new start, level_o=2; re-enable -> the remaining 2 frames are sent.
